// File: rtl/otter_mem_pkg.sv
// Shared memory-access types for the load/store unit and the size/extend stage.
package otter_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef enum logic {
    SIGNED   = 1'b0,
    UNSIGNED = 1'b1
  } mem_sign_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } lsu_state_t;

  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  // Unshifted byte-enable pattern for an access of the given size.
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    logic [3:0] m;
    case (sz)
      SZ_BYTE: m = 4'b0001;
      SZ_HALF: m = 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational alignment check, byte-enable generation and store-data lane shift.
module lsu_align
  import otter_mem_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic        legal,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh
);

  // Legality depends on size and low address bits; loads always read the full word.
  always_comb begin
    legal    = 1'b0;
    be       = 4'hF;
    wdata_sh = '0;
    case (size)
      SZ_BYTE: legal = 1'b1;
      SZ_HALF: legal = ~offset[0];
      SZ_WORD: legal = (offset == 2'b00);
      default: legal = 1'b0;
    endcase
    if (we) begin
      be       = size_mask(size) << offset;
      wdata_sh = wdata << {offset, 3'b000};
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request, runs a single bus transaction with
// timeout, and presents the raw captured load word for the size/extend stage.
module load_store_unit
  import otter_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    we,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  input  logic [1:0]              size,
  input  logic                    sign,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  load_store_unit_if.master       bus,
  output logic [31:0]             ld_data,
  output logic [1:0]              ld_byte_sel,
  output logic [1:0]              ld_size,
  output logic                    ld_sign
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt;

  logic             legal;
  logic [3:0]       be_c;
  logic [31:0]      wdata_sh_c;
  logic             accept;

  logic             lat_we;
  logic [31:0]      lat_addr;
  logic [1:0]       lat_size;
  logic             lat_sign;
  logic [3:0]       lat_be;
  logic [31:0]      lat_wdata;

  lsu_align u_align (
    .we       (we),
    .offset   (addr[1:0]),
    .size     (size),
    .wdata    (wdata),
    .legal    (legal),
    .be       (be_c),
    .wdata_sh (wdata_sh_c)
  );

  assign accept = (state == ST_IDLE) && req && legal;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode plus status and bus outputs; bus is driven only while in BUS.
  always_comb begin
    state_nx      = state;
    busy          = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    bus.bus_valid = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_wdata = '0;
    bus.bus_be    = 4'b0000;
    case (state)
      ST_IDLE: begin
        if (req) state_nx = legal ? ST_BUS : ST_ERR;
      end
      ST_BUS: begin
        busy          = 1'b1;
        bus.bus_valid = 1'b1;
        bus.bus_we    = lat_we;
        bus.bus_addr  = {lat_addr[31:2], 2'b00};
        bus.bus_wdata = lat_wdata;
        bus.bus_be    = lat_be;
        if (bus.bus_ready)          state_nx = ST_DONE;
        else if (cnt == CNT_LAST)   state_nx = ST_ERR;
      end
      ST_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      ST_ERR: begin
        busy     = 1'b1;
        err      = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Ready-less cycle counter, restarted on each bus access.
  always_ff @(posedge clk) begin
    if (rst)                                cnt <= '0;
    else if (accept)                        cnt <= '0;
    else if (state == ST_BUS && !bus.bus_ready) cnt <= cnt + CNT_W'(1);
  end

  // Request latch; the store lane shift and byte enables are captured pre-computed.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_size  <= 2'b00;
      lat_sign  <= 1'b0;
      lat_be    <= 4'b0000;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_we    <= we;
      lat_addr  <= addr;
      lat_size  <= size;
      lat_sign  <= sign;
      lat_be    <= be_c;
      lat_wdata <= wdata_sh_c;
    end
  end

  // Load result capture; only a completed load updates these.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_data     <= '0;
      ld_byte_sel <= 2'b00;
      ld_size     <= 2'b00;
      ld_sign     <= 1'b0;
    end else if (state == ST_BUS && bus.bus_ready && !lat_we) begin
      ld_data     <= bus.bus_rdata;
      ld_byte_sel <= lat_addr[1:0];
      ld_size     <= lat_size;
      ld_sign     <= lat_sign;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a transaction-level reference model.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        sign;
  logic        busy, done, err;
  logic [31:0] ld_data;
  logic [1:0]  ld_byte_sel, ld_size;
  logic        ld_sign;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .size        (size),
    .sign        (sign),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .bus         (bus_if),
    .ld_data     (ld_data),
    .ld_byte_sel (ld_byte_sel),
    .ld_size     (ld_size),
    .ld_sign     (ld_sign)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Expected load-result registers, as the core would see them.
  logic [31:0] m_ld_data;
  logic [1:0]  m_ld_sel, m_ld_size;
  logic        m_ld_sign;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ld(input string tag);
    chk({tag, "_ld_data"}, ld_data, m_ld_data);
    chk({tag, "_ld_sel"},  32'(ld_byte_sel), 32'(m_ld_sel));
    chk({tag, "_ld_size"}, 32'(ld_size), 32'(m_ld_size));
    chk({tag, "_ld_sign"}, 32'(ld_sign), 32'(m_ld_sign));
  endtask

  // Random core-side activity while the unit is busy; all of it must be ignored.
  task automatic scramble();
    req   = 1'($urandom);
    we    = 1'($urandom);
    addr  = $urandom;
    wdata = $urandom;
    size  = 2'($urandom);
    sign  = 1'($urandom);
  endtask

  // One request starting at a negedge in IDLE; delay = ready-less cycles before ready.
  task automatic access(input logic a_we, input logic [31:0] a_addr, input logic [31:0] a_wdata,
                        input logic [1:0] a_size, input logic a_sign,
                        input logic [31:0] a_rdata, input int delay);
    int          off;
    int          nb;
    bit          legal;
    bit          finished;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    off   = int'(a_addr[1:0]);
    nb    = (a_size == 2'd0) ? 1 : (a_size == 2'd1) ? 2 : 4;
    legal = (a_size != 2'b11) && ((off % nb) == 0);
    ebe   = a_we ? 4'((((1 << nb) - 1) << off) & 15) : 4'hF;
    ewd   = a_we ? (a_wdata << (8 * off)) : 32'h0;

    chk("idle_busy", 32'(busy), 32'd0);
    req = 1'b1; we = a_we; addr = a_addr; wdata = a_wdata; size = a_size; sign = a_sign;
    bus_if.bus_ready = 1'($urandom);
    bus_if.bus_rdata = $urandom;
    @(negedge clk);
    scramble();
    bus_if.bus_ready = 1'b0;

    if (!legal) begin
      chk("bad_err",   32'(err), 32'd1);
      chk("bad_done",  32'(done), 32'd0);
      chk("bad_valid", 32'(bus_if.bus_valid), 32'd0);
      chk("bad_busy",  32'(busy), 32'd1);
      check_ld("bad");
      @(negedge clk);
      req = 1'b0;
      chk("bad_after_busy", 32'(busy), 32'd0);
      chk("bad_after_err",  32'(err), 32'd0);
      return;
    end

    finished = 1'b0;
    for (int k = 0; k < TO && !finished; k++) begin
      chk("bus_valid", 32'(bus_if.bus_valid), 32'd1);
      chk("bus_addr",  bus_if.bus_addr, a_addr & 32'hFFFF_FFFC);
      chk("bus_be",    32'(bus_if.bus_be), 32'(ebe));
      chk("bus_wdata", bus_if.bus_wdata, ewd);
      chk("bus_we",    32'(bus_if.bus_we), 32'(a_we));
      chk("bus_busy",  32'(busy), 32'd1);
      chk("bus_done",  32'(done), 32'd0);
      if (k == delay) begin
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = a_rdata;
        @(negedge clk);
        scramble();
        bus_if.bus_ready = 1'($urandom);
        bus_if.bus_rdata = $urandom;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_err",   32'(err), 32'd0);
        chk("done_valid", 32'(bus_if.bus_valid), 32'd0);
        if (!a_we) begin
          m_ld_data = a_rdata;
          m_ld_sel  = a_addr[1:0];
          m_ld_size = a_size;
          m_ld_sign = a_sign;
        end
        check_ld("done");
        finished = 1'b1;
      end else begin
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = $urandom;
        @(negedge clk);
        scramble();
      end
    end

    if (!finished) begin
      chk("to_err",   32'(err), 32'd1);
      chk("to_valid", 32'(bus_if.bus_valid), 32'd0);
      chk("to_done",  32'(done), 32'd0);
      check_ld("to");
    end

    @(negedge clk);
    req = 1'b0;
    bus_if.bus_ready = 1'b0;
    chk("end_busy",  32'(busy), 32'd0);
    chk("end_done",  32'(done), 32'd0);
    chk("end_err",   32'(err), 32'd0);
    chk("end_valid", 32'(bus_if.bus_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [1:0]  rs;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; size = 2'b00; sign = 1'b0;
    bus_if.bus_ready = 1'b0;
    bus_if.bus_rdata = '0;
    m_ld_data = '0; m_ld_sel = 2'b00; m_ld_size = 2'b00; m_ld_sign = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state.
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_valid", 32'(bus_if.bus_valid), 32'd0);
    chk("rst_we",    32'(bus_if.bus_we), 32'd0);
    chk("rst_addr",  bus_if.bus_addr, 32'd0);
    chk("rst_wdata", bus_if.bus_wdata, 32'd0);
    chk("rst_be",    32'(bus_if.bus_be), 32'd0);
    check_ld("rst");
    rst = 1'b0;
    @(negedge clk);

    // Word load with immediate ready.
    access(1'b0, 32'h0000_0100, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 0);
    chk("w_ld_data", ld_data, 32'hDEAD_BEEF);
    chk("w_ld_size", 32'(ld_size), 32'd2);
    // Byte store to the top lane.
    access(1'b1, 32'h0000_0203, 32'h0000_00AB, 2'b00, 1'b0, 32'h1234_5678, 1);
    // Misaligned half and illegal size.
    access(1'b0, 32'h0000_0101, 32'h0, 2'b01, 1'b0, 32'h0, 0);
    access(1'b0, 32'h0000_0000, 32'h0, 2'b11, 1'b0, 32'h0, 0);
    // Timeout with ready never asserted.
    access(1'b0, 32'h0000_0040, 32'h0, 2'b10, 1'b1, 32'h0, TO);
    // Half load, then a store that must not disturb the load result.
    access(1'b0, 32'h0000_0082, 32'h0, 2'b01, 1'b1, 32'hCAFE_F00D, 2);
    access(1'b1, 32'h0000_0082, 32'h0000_BEEF, 2'b01, 1'b0, 32'h0, 0);

    // Randomized mix of loads, stores, bad alignments and timeouts.
    for (int i = 0; i < 150; i++) begin
      r  = $urandom;
      rs = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      access(1'($urandom), r, $urandom, rs, 1'($urandom), $urandom, $urandom_range(0, TO));
    end

    // Reset in the middle of a bus access after three ready-less cycles.
    req = 1'b1; we = 1'b0; addr = 32'h0000_0300; size = 2'b10; sign = 1'b0;
    @(negedge clk);
    req = 1'b0;
    bus_if.bus_ready = 1'b0;
    chk("mid_valid1", 32'(bus_if.bus_valid), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_valid3", 32'(bus_if.bus_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ld_data = '0; m_ld_sel = 2'b00; m_ld_size = 2'b00; m_ld_sign = 1'b0;
    chk("mid_valid", 32'(bus_if.bus_valid), 32'd0);
    chk("mid_busy",  32'(busy), 32'd0);
    chk("mid_done",  32'(done), 32'd0);
    chk("mid_err",   32'(err), 32'd0);
    check_ld("mid");
    @(negedge clk);
    chk("mid2_done", 32'(done), 32'd0);
    chk("mid2_err",  32'(err), 32'd0);
    chk("mid2_busy", 32'(busy), 32'd0);

    // Unit still works after the abort.
    access(1'b0, 32'h0000_0304, 32'h0, 2'b00, 1'b1, 32'h0BAD_F00D, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
